// File: rtl/fsm_mult_control.sv
// fsm_mult_control
//   Sequencer for a floating-point multiplier datapath. One multiplication is
//   started by beg_FSM in IDLE. The sequence is:
//   operand load, zero check, exponent add, bias subtract,
//   SGF_LAT cycles of significand multiply, normalize, exception check,
//   result store, then wait for ack_FSM.
//   A zero operand short-circuits straight to STORE with a forced-zero result.
//
// Parameters
//   SGF_LAT          cycles from load_sgf_o to a valid product (1..15)
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   beg_FSM          start request (level, sampled in IDLE only)
//   ack_FSM          result acknowledge (sampled in READY only)
//   zero_flag_i      either operand is zero (valid in ZERO_CHK)
//   Mult_shift_i     product MSB set, normalize needed (valid in NORM)
//   overflow_flag_i  exponent overflow (valid in EXC)
//   underflow_flag_i exponent underflow (valid in EXC)
//   load_op_o        operand register load enable
//   load_exp_o       exponent register load enable
//   exp_sel_o        exponent adder select: 00 add, 01 sub bias, 10 increment
//   load_sgf_o       significand multiplier start pulse
//   ctrl_norm_o      select 1-bit right-shifted product
//   zero_res_o       force zero result
//   exc_res_o        force exception result
//   load_result_o    final result register load enable
//   ready_o          result valid, held until acknowledged
//   busy_o           high in every state except IDLE
module fsm_mult_control #(
  parameter int unsigned SGF_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beg_FSM,
  input  logic       ack_FSM,
  input  logic       zero_flag_i,
  input  logic       Mult_shift_i,
  input  logic       overflow_flag_i,
  input  logic       underflow_flag_i,
  output logic       load_op_o,
  output logic       load_exp_o,
  output logic [1:0] exp_sel_o,
  output logic       load_sgf_o,
  output logic       ctrl_norm_o,
  output logic       zero_res_o,
  output logic       exc_res_o,
  output logic       load_result_o,
  output logic       ready_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD_OP  = 4'd1,
    ZERO_CHK = 4'd2,
    EXP_ADD  = 4'd3,
    BIAS     = 4'd4,
    SGF_MULT = 4'd5,
    NORM     = 4'd6,
    EXC      = 4'd7,
    STORE    = 4'd8,
    READY    = 4'd9
  } state_t;

  // Last counter value spent in SGF_MULT; the state is held SGF_LAT cycles.
  localparam logic [3:0] SGF_LAST = 4'(SGF_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       zero_q, zero_d;
  logic       exc_q, exc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      zero_q  <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    zero_d        = zero_q;
    exc_d         = exc_q;
    load_op_o     = 1'b0;
    load_exp_o    = 1'b0;
    exp_sel_o     = 2'b00;
    load_sgf_o    = 1'b0;
    ctrl_norm_o   = 1'b0;
    zero_res_o    = 1'b0;
    exc_res_o     = 1'b0;
    load_result_o = 1'b0;
    ready_o       = 1'b0;
    busy_o        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = 4'd0;
        zero_d = 1'b0;
        exc_d  = 1'b0;
        if (beg_FSM) state_d = LOAD_OP;
      end
      LOAD_OP: begin
        busy_o    = 1'b1;
        load_op_o = 1'b1;
        state_d   = ZERO_CHK;
      end
      ZERO_CHK: begin
        busy_o = 1'b1;
        // A zero operand bypasses exponent, multiply and exception steps.
        if (zero_flag_i) begin
          zero_d  = 1'b1;
          state_d = STORE;
        end else begin
          state_d = EXP_ADD;
        end
      end
      EXP_ADD: begin
        busy_o     = 1'b1;
        load_exp_o = 1'b1;
        exp_sel_o  = 2'b00;
        state_d    = BIAS;
      end
      BIAS: begin
        busy_o     = 1'b1;
        load_exp_o = 1'b1;
        exp_sel_o  = 2'b01;
        cnt_d      = 4'd0;
        state_d    = SGF_MULT;
      end
      SGF_MULT: begin
        busy_o     = 1'b1;
        load_sgf_o = (cnt_q == 4'd0);
        if (cnt_q == SGF_LAST) begin
          cnt_d   = 4'd0;
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      NORM: begin
        // Mealy: the shift decision comes straight from the product MSB.
        busy_o      = 1'b1;
        exp_sel_o   = 2'b10;
        ctrl_norm_o = Mult_shift_i;
        load_exp_o  = Mult_shift_i;
        state_d     = EXC;
      end
      EXC: begin
        busy_o = 1'b1;
        if (overflow_flag_i || underflow_flag_i) exc_d = 1'b1;
        state_d = STORE;
      end
      STORE: begin
        busy_o        = 1'b1;
        load_result_o = 1'b1;
        zero_res_o    = zero_q;
        exc_res_o     = exc_q;
        state_d       = READY;
      end
      READY: begin
        busy_o     = 1'b1;
        ready_o    = 1'b1;
        zero_res_o = zero_q;
        exc_res_o  = exc_q;
        if (ack_FSM) begin
          zero_d  = 1'b0;
          exc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        // Unused encodings recover to IDLE with every output low.
        state_d = IDLE;
        cnt_d   = 4'd0;
        zero_d  = 1'b0;
        exc_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_mult_control.sv
// tb_fsm_mult_control
//   Directed bench for fsm_mult_control. The main instance uses SGF_LAT=3;
//   two extra instances (SGF_LAT=1 and 15) share all inputs and are used for
//   the latency comparison after a reset.
//   Output vector layout (11 bits, MSB first):
//     load_op, load_exp, exp_sel[1:0], load_sgf, ctrl_norm,
//     zero_res, exc_res, load_result, ready, busy
module tb_fsm_mult_control;

  logic clk, rst, beg_FSM, ack_FSM, zero_flag_i, Mult_shift_i;
  logic overflow_flag_i, underflow_flag_i;

  logic       lop3, lexp3, lsgf3, norm3, zr3, er3, lres3, rdy3, bsy3;
  logic [1:0] sel3;
  logic       lop1, lexp1, lsgf1, norm1, zr1, er1, lres1, rdy1, bsy1;
  logic [1:0] sel1;
  logic       lop15, lexp15, lsgf15, norm15, zr15, er15, lres15, rdy15, bsy15;
  logic [1:0] sel15;

  logic [10:0] v3, v1, v15;
  assign v3  = {lop3, lexp3, sel3, lsgf3, norm3, zr3, er3, lres3, rdy3, bsy3};
  assign v1  = {lop1, lexp1, sel1, lsgf1, norm1, zr1, er1, lres1, rdy1, bsy1};
  assign v15 = {lop15, lexp15, sel15, lsgf15, norm15, zr15, er15, lres15, rdy15, bsy15};

  fsm_mult_control #(.SGF_LAT(3)) u3 (
    .clk(clk), .rst(rst), .beg_FSM(beg_FSM), .ack_FSM(ack_FSM),
    .zero_flag_i(zero_flag_i), .Mult_shift_i(Mult_shift_i),
    .overflow_flag_i(overflow_flag_i), .underflow_flag_i(underflow_flag_i),
    .load_op_o(lop3), .load_exp_o(lexp3), .exp_sel_o(sel3), .load_sgf_o(lsgf3),
    .ctrl_norm_o(norm3), .zero_res_o(zr3), .exc_res_o(er3),
    .load_result_o(lres3), .ready_o(rdy3), .busy_o(bsy3)
  );

  fsm_mult_control #(.SGF_LAT(1)) u1 (
    .clk(clk), .rst(rst), .beg_FSM(beg_FSM), .ack_FSM(ack_FSM),
    .zero_flag_i(zero_flag_i), .Mult_shift_i(Mult_shift_i),
    .overflow_flag_i(overflow_flag_i), .underflow_flag_i(underflow_flag_i),
    .load_op_o(lop1), .load_exp_o(lexp1), .exp_sel_o(sel1), .load_sgf_o(lsgf1),
    .ctrl_norm_o(norm1), .zero_res_o(zr1), .exc_res_o(er1),
    .load_result_o(lres1), .ready_o(rdy1), .busy_o(bsy1)
  );

  fsm_mult_control #(.SGF_LAT(15)) u15 (
    .clk(clk), .rst(rst), .beg_FSM(beg_FSM), .ack_FSM(ack_FSM),
    .zero_flag_i(zero_flag_i), .Mult_shift_i(Mult_shift_i),
    .overflow_flag_i(overflow_flag_i), .underflow_flag_i(underflow_flag_i),
    .load_op_o(lop15), .load_exp_o(lexp15), .exp_sel_o(sel15), .load_sgf_o(lsgf15),
    .ctrl_norm_o(norm15), .zero_res_o(zr15), .exc_res_o(er15),
    .load_result_o(lres15), .ready_o(rdy15), .busy_o(bsy15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkv(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  localparam logic [10:0] V_IDLE  = 11'b0_0_00_0_0_0_0_0_0_0;
  localparam logic [10:0] V_LOAD  = 11'b1_0_00_0_0_0_0_0_0_1;
  localparam logic [10:0] V_BUSY  = 11'b0_0_00_0_0_0_0_0_0_1;
  localparam logic [10:0] V_EADD  = 11'b0_1_00_0_0_0_0_0_0_1;
  localparam logic [10:0] V_BIAS  = 11'b0_1_01_0_0_0_0_0_0_1;
  localparam logic [10:0] V_SGF1  = 11'b0_0_00_1_0_0_0_0_0_1;
  localparam logic [10:0] V_NORM0 = 11'b0_0_10_0_0_0_0_0_0_1;
  localparam logic [10:0] V_NORM1 = 11'b0_1_10_0_1_0_0_0_0_1;
  localparam logic [10:0] V_STORE = 11'b0_0_00_0_0_0_0_1_0_1;
  localparam logic [10:0] V_READY = 11'b0_0_00_0_0_0_0_0_1_1;
  localparam logic [10:0] V_ZSTO  = 11'b0_0_00_0_0_1_0_1_0_1;
  localparam logic [10:0] V_ZRDY  = 11'b0_0_00_0_0_1_0_0_1_1;
  localparam logic [10:0] V_ESTO  = 11'b0_0_00_0_0_0_1_1_0_1;
  localparam logic [10:0] V_ERDY  = 11'b0_0_00_0_0_0_1_0_1_1;

  // Expected outputs on cycles 1..11 of a normal SGF_LAT=3 run, no flags.
  logic [10:0] exp_n [11];
  int l1, l3, l15;

  initial begin
    exp_n = '{V_LOAD, V_BUSY, V_EADD, V_BIAS, V_SGF1, V_BUSY, V_BUSY,
              V_NORM0, V_BUSY, V_STORE, V_READY};
    rst = 1'b0; beg_FSM = 1'b0; ack_FSM = 1'b0; zero_flag_i = 1'b0;
    Mult_shift_i = 1'b0; overflow_flag_i = 1'b0; underflow_flag_i = 1'b0;

    // Reset state
    tick(); tick();
    chkv("reset_state", v3, V_IDLE);
    rst = 1'b1;
    tick(); tick();
    chkv("idle_after_release", v3, V_IDLE);

    // Normal path, no flags
    beg_FSM = 1'b1;
    tick();
    beg_FSM = 1'b0;
    for (int c = 0; c < 11; c++) begin
      chkv($sformatf("normal_c%0d", c + 1), v3, exp_n[c]);
      if (c < 10) tick();
    end
    ack_FSM = 1'b1;
    tick();
    ack_FSM = 1'b0;
    chkv("normal_ack_idle", v3, V_IDLE);

    // Zero path
    beg_FSM = 1'b1;
    tick();
    beg_FSM = 1'b0;
    chkv("zero_c1", v3, V_LOAD);
    tick();
    zero_flag_i = 1'b1;
    chkv("zero_c2", v3, V_BUSY);
    tick();
    zero_flag_i = 1'b0;
    chkv("zero_c3_store", v3, V_ZSTO);
    tick();
    chkv("zero_c4_ready", v3, V_ZRDY);
    ack_FSM = 1'b1;
    tick();
    ack_FSM = 1'b0;
    chkv("zero_ack_idle", v3, V_IDLE);

    // Normalize shift and overflow; stray ack outside READY
    beg_FSM = 1'b1;
    tick();
    beg_FSM = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    Mult_shift_i = 1'b1;
    tick();
    chkv("shift_norm", v3, V_NORM1);
    Mult_shift_i = 1'b0;
    ack_FSM = 1'b1;
    tick();
    ack_FSM = 1'b0;
    overflow_flag_i = 1'b1;
    chkv("ovf_exc", v3, V_BUSY);
    tick();
    overflow_flag_i = 1'b0;
    chkv("ovf_store", v3, V_ESTO);
    tick();
    chkv("ovf_ready", v3, V_ERDY);
    tick();
    chkv("ovf_ready_hold", v3, V_ERDY);
    ack_FSM = 1'b1;
    tick();
    ack_FSM = 1'b0;
    chkv("ovf_ack_idle", v3, V_IDLE);

    // beg held high; ack delayed; ack with beg high
    beg_FSM = 1'b1;
    tick();
    for (int c = 1; c < 11; c++) tick();
    chkv("hold_ready_c11", v3, V_READY);
    for (int c = 0; c < 5; c++) begin
      tick();
      chkv($sformatf("hold_ready_wait%0d", c), v3, V_READY);
    end
    ack_FSM = 1'b1;
    tick();
    ack_FSM = 1'b0;
    chkv("ack_beg_idle", v3, V_IDLE);
    tick();
    beg_FSM = 1'b0;
    chkv("restart_load", v3, V_LOAD);
    for (int c = 1; c < 11; c++) tick();
    chkv("restart_ready", v3, V_READY);
    ack_FSM = 1'b1;
    tick();
    ack_FSM = 1'b0;

    // Asynchronous reset during SGF_MULT cycle 2
    beg_FSM = 1'b1;
    tick();
    beg_FSM = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    chkv("pre_rst_sgf2", v3, V_BUSY);
    #2 rst = 1'b0;
    #1;
    chkv("async_rst_u3", v3, V_IDLE);
    chkv("async_rst_u15", v15, V_IDLE);
    tick();
    #3 rst = 1'b1;
    tick();
    chkv("post_rst_idle", v3, V_IDLE);

    // Latency for SGF_LAT = 1, 3, 15 from a fresh start
    l1 = 0; l3 = 0; l15 = 0;
    beg_FSM = 1'b1;
    tick();
    beg_FSM = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (rdy1  && l1  == 0) l1  = c;
      if (rdy3  && l3  == 0) l3  = c;
      if (rdy15 && l15 == 0) l15 = c;
      tick();
    end
    chki("latency_lat1", l1, 9);
    chki("latency_lat3", l3, 11);
    chki("latency_lat15", l15, 23);
    ack_FSM = 1'b1;
    tick();
    ack_FSM = 1'b0;
    chkv("final_idle_u1", v1, V_IDLE);
    chkv("final_idle_u15", v15, V_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_mult_control.md
FSM_MULT_CONTROL -- requirements
Module: fsm_mult_control

Interface
REQ-001 Parameter SGF_LAT, default 3: cycles the significand multiplier needs from load to valid product; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  module reset; asynchronous, active-low.
REQ-004 beg_FSM  input  1  start request for one multiplication; level, sampled only in IDLE.
REQ-005 ack_FSM  input  1  consumer acknowledge of the result; sampled only in READY.
REQ-006 zero_flag_i  input  1  either operand is zero, valid in ZERO_CHK.
REQ-007 Mult_shift_i  input  1  product MSB set (normalize required), valid in NORM.
REQ-008 overflow_flag_i, underflow_flag_i  input  1 each  exponent exception flags, valid in EXC.
REQ-009 load_op_o  output  1  load enable for the operand input registers (first phase).
REQ-010 load_exp_o  output  1  load enable for the exponent register.
REQ-011 exp_sel_o  output  2  exponent adder select: 00 add exponents, 01 subtract bias, 10 increment.
REQ-012 load_sgf_o  output  1  start pulse for the significand multiplier.
REQ-013 ctrl_norm_o  output  1  selects the 1-bit right-shifted product.
REQ-014 zero_res_o, exc_res_o  output  1 each  force zero result / force exception result (overflow or underflow).
REQ-015 load_result_o  output  1  load enable for the final result register.
REQ-016 ready_o  output  1  result valid; held until acknowledged.
REQ-017 busy_o  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, LOAD_OP, ZERO_CHK, EXP_ADD, BIAS, SGF_MULT, NORM, EXC, STORE, READY; outputs are registered-state decodes (Moore), except where noted.
REQ-019 IDLE: all outputs 0; beg_FSM=1 -> LOAD_OP, else stay.
REQ-020 LOAD_OP: load_op_o=1 for exactly one cycle -> ZERO_CHK.
REQ-021 ZERO_CHK: zero_flag_i=1 -> STORE with zero_res_o latched to 1; else -> EXP_ADD.
REQ-022 EXP_ADD: load_exp_o=1, exp_sel_o=00 -> BIAS.
REQ-023 BIAS: load_exp_o=1, exp_sel_o=01 -> SGF_MULT.
REQ-024 SGF_MULT: load_sgf_o=1 in the first SGF_MULT cycle only; 4-bit counter cleared on entry, state held exactly SGF_LAT cycles -> NORM.
REQ-025 NORM: ctrl_norm_o=Mult_shift_i and load_exp_o=Mult_shift_i with exp_sel_o=10 (Mealy, one cycle) -> EXC.
REQ-026 EXC: overflow_flag_i or underflow_flag_i =1 -> exc_res_o latched to 1; always -> STORE.
REQ-027 STORE: load_result_o=1 for one cycle -> READY.
REQ-028 READY: ready_o=1; ack_FSM=1 -> IDLE and clear zero_res_o/exc_res_o; else stay.
REQ-029 Latency beg_FSM sampled to ready_o high: SGF_LAT+8 cycles normal path (11 at default); 4 cycles zero path.
REQ-030 beg_FSM outside IDLE ignored; ack_FSM outside READY ignored; beg_FSM and ack_FSM both high in READY -> IDLE only, new start requires beg_FSM high in IDLE.
REQ-031 zero_res_o and exc_res_o never both 1; zero path skips exception check.
REQ-032 Any unreachable state encoding -> IDLE on next edge with all outputs 0.
REQ-033 Every load/select pulse is exactly one cycle; no two of load_op_o, load_sgf_o, load_result_o high in the same cycle.

Reset
REQ-034 rst=0 forces IDLE, counter 0, all outputs 0 immediately, regardless of clk, including mid-operation.
REQ-035 After rst release, first beg_FSM sampled starts a full fresh sequence; no partial state retained.

Verification
REQ-036 SGF_LAT=3, nonzero operands, no flags: beg_FSM pulse -> load_op_o, exp_sel 00, 01, load_sgf_o, 3 SGF cycles, load_result_o; ready_o at cycle 11; ack_FSM -> IDLE next edge.
REQ-037 zero_flag_i=1 in ZERO_CHK -> zero_res_o=1, load_result_o cycle 3, ready_o cycle 4, no load_exp_o/load_sgf_o pulses.
REQ-038 Mult_shift_i=1 in NORM -> ctrl_norm_o=1, load_exp_o=1, exp_sel_o=10 same cycle; overflow_flag_i=1 in EXC -> exc_res_o=1 through READY.
REQ-039 rst low during SGF_MULT cycle 2 -> all outputs 0 asynchronously; after release, beg_FSM produces full 11-cycle sequence.
REQ-040 beg_FSM held high throughout, ack_FSM held low 5 cycles in READY -> ready_o held, no restart; ack with beg high -> IDLE then new start one cycle later.
REQ-041 SGF_LAT=1 and SGF_LAT=15 builds -> ready_o at cycles 9 and 23 respectively.
